// File: rtl/rgb565_src_arbiter.sv
// ---------------------------------------------------------------------------
// rgb565_src_arbiter
//
// Purpose
//   Two pixel sources (S0 = camera, S1 = overlay/GUI) share one
//   RGB888 -> RGB565 truncating converter. Arbitration is round-robin per
//   burst. A grant lasts until the granted source presents a beat with last=1,
//   or until BURST_MAX beats have been accepted. The converted pixel leaves
//   through a single registered valid/ready stage, tagged with its source id.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_s0_valid/o_s0_ready   S0 handshake
//   i_s0_r/g/b, i_s0_last   S0 pixel (8 bits per channel) and end of burst
//   i_s1_*, o_s1_ready      same set for S1
//   o_valid/i_ready         output handshake
//   o_rgb565                {r[7:3], g[7:2], b[7:3]}
//   o_last                  last flag of the accepted source beat
//   o_src                   0 = S0, 1 = S1
//   o_busy                  high while a grant is held
//   o_dbg_state             arbiter state (0 idle, 1 grant S0, 2 grant S1)
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid and ready are both high; a source holding valid without ready keeps
// its data stable; ready never depends combinationally on the same side's valid.
// ---------------------------------------------------------------------------
module rgb565_src_arbiter #(
    parameter int BURST_MAX = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_s0_valid,
    output logic        o_s0_ready,
    input  logic [7:0]  i_s0_r,
    input  logic [7:0]  i_s0_g,
    input  logic [7:0]  i_s0_b,
    input  logic        i_s0_last,
    input  logic        i_s1_valid,
    output logic        o_s1_ready,
    input  logic [7:0]  i_s1_r,
    input  logic [7:0]  i_s1_g,
    input  logic [7:0]  i_s1_b,
    input  logic        i_s1_last,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_rgb565,
    output logic        o_last,
    output logic        o_src,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(BURST_MAX + 1);
    // Count value at which the next accepted beat is the BURST_MAX-th one.
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_last_served;
    logic            r_valid;
    logic [15:0]     r_rgb565;
    logic            r_last;
    logic            r_src;

    logic            w_out_free;
    logic            w_s0_ready;
    logic            w_s1_ready;
    logic            w_accept;
    logic [7:0]      w_r;
    logic [7:0]      w_g;
    logic [7:0]      w_b;
    logic            w_sel_last;
    logic            w_burst_end;

    // Output stage can take a new beat when empty or draining this cycle.
    assign w_out_free  = !r_valid || i_ready;
    assign w_s0_ready  = (r_state == S_GRANT0) && w_out_free;
    assign w_s1_ready  = (r_state == S_GRANT1) && w_out_free;
    assign w_accept    = (w_s0_ready && i_s0_valid) || (w_s1_ready && i_s1_valid);

    assign w_r         = (r_state == S_GRANT1) ? i_s1_r : i_s0_r;
    assign w_g         = (r_state == S_GRANT1) ? i_s1_g : i_s0_g;
    assign w_b         = (r_state == S_GRANT1) ? i_s1_b : i_s0_b;
    assign w_sel_last  = (r_state == S_GRANT1) ? i_s1_last : i_s0_last;
    assign w_burst_end = w_sel_last || (r_count == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_last_served <= 1'b1;
            r_valid       <= 1'b0;
            r_rgb565      <= 16'h0000;
            r_last        <= 1'b0;
            r_src         <= 1'b0;
        end else begin
            // Output register: capture on accept, otherwise drain on ready.
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_rgb565 <= {w_r[7:3], w_g[7:2], w_b[7:3]};
                r_last   <= w_sel_last;
                r_src    <= (r_state == S_GRANT1);
            end else if (i_ready) begin
                r_valid  <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    // Tie goes to the source that was not served last.
                    if (i_s0_valid && (!i_s1_valid || r_last_served)) begin
                        r_state <= S_GRANT0;
                    end else if (i_s1_valid) begin
                        r_state <= S_GRANT1;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    if (w_accept) begin
                        if (w_burst_end) begin
                            r_state       <= S_IDLE;
                            r_count       <= '0;
                            r_last_served <= (r_state == S_GRANT1);
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_s0_ready  = w_s0_ready;
    assign o_s1_ready  = w_s1_ready;
    assign o_valid     = r_valid;
    assign o_rgb565    = r_rgb565;
    assign o_last      = r_last;
    assign o_src       = r_src;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rgb565_src_arbiter.sv
module tb_rgb565_src_arbiter;

    localparam int BM = 4;

    logic        clk;
    logic        i_rst;
    logic        i_s0_valid, i_s0_last, i_s1_valid, i_s1_last;
    logic [7:0]  i_s0_r, i_s0_g, i_s0_b, i_s1_r, i_s1_g, i_s1_b;
    logic        i_ready;
    logic        o_s0_ready, o_s1_ready, o_valid, o_last, o_src, o_busy;
    logic [15:0] o_rgb565;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];
    logic [17:0] out_log[$];
    int          n_out0 = 0;
    int          n_out1 = 0;
    logic        mon_en = 0;
    logic        done0, done1;

    rgb565_src_arbiter #(.BURST_MAX(BM)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_s0_valid(i_s0_valid), .o_s0_ready(o_s0_ready),
        .i_s0_r(i_s0_r), .i_s0_g(i_s0_g), .i_s0_b(i_s0_b), .i_s0_last(i_s0_last),
        .i_s1_valid(i_s1_valid), .o_s1_ready(o_s1_ready),
        .i_s1_r(i_s1_r), .i_s1_g(i_s1_g), .i_s1_b(i_s1_b), .i_s1_last(i_s1_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_rgb565(o_rgb565),
        .o_last(o_last), .o_src(o_src), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        i_rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_rst  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one beat, waits for the handshake, pushes the expected output.
    task automatic send(input int s, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic l);
        int   t;
        logic rdy;
        if (s == 0) begin
            i_s0_valid = 1'b1; i_s0_r = r; i_s0_g = g; i_s0_b = b; i_s0_last = l;
        end else begin
            i_s1_valid = 1'b1; i_s1_r = r; i_s1_g = g; i_s1_b = b; i_s1_last = l;
        end
        t   = 0;
        rdy = 1'b0;
        while (!rdy && t < 2000) begin
            @(negedge clk);
            rdy = (s == 0) ? o_s0_ready : o_s1_ready;
            t++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout src=%0d actual=no_ready expected=ready", s);
        end else if (s == 0) begin
            exp_q0.push_back({l, r[7:3], g[7:2], b[7:3]});
        end else begin
            exp_q1.push_back({l, r[7:3], g[7:2], b[7:3]});
        end
        @(posedge clk);
        #1;
        if (s == 0) i_s0_valid = 1'b0;
        else        i_s1_valid = 1'b0;
    endtask

    task automatic src_stream(input int s, input int total);
        int sent = 0;
        int len;
        int gap;
        while (sent < total) begin
            len = $urandom_range(1, 7);
            if (len > total - sent) len = total - sent;
            for (int j = 0; j < len; j++) begin
                send(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), (j == len - 1));
                gap = $urandom_range(0, 3);
                if (gap > 1) begin
                    repeat (gap - 1) @(posedge clk);
                    #1;
                end
            end
            sent += len;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((o_valid || exp_q0.size() != 0 || exp_q1.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", (o_valid || exp_q0.size() != 0 || exp_q1.size() != 0), 0);
        @(negedge clk);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        logic        hold_pend;
        logic [17:0] hold_val;
        logic [16:0] e;
        int          gcnt;
        hold_pend = 1'b0;
        gcnt      = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                hold_pend = 1'b0;
                gcnt      = 0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", o_valid, 1);
                    chk("hold_data", {o_src, o_last, o_rgb565}, hold_val);
                end
                hold_pend = o_valid && !i_ready;
                hold_val  = {o_src, o_last, o_rgb565};
                if (o_valid && i_ready) begin
                    out_log.push_back({o_src, o_last, o_rgb565});
                    if (o_src == 1'b0) begin
                        if (exp_q0.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL sb_s0 actual=%0h expected=none", {o_last, o_rgb565});
                        end else begin
                            e = exp_q0.pop_front();
                            chk("sb_s0", {o_last, o_rgb565}, e);
                            n_out0++;
                        end
                    end else begin
                        if (exp_q1.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL sb_s1 actual=%0h expected=none", {o_last, o_rgb565});
                        end else begin
                            e = exp_q1.pop_front();
                            chk("sb_s1", {o_last, o_rgb565}, e);
                            n_out1++;
                        end
                    end
                end
                if (!o_busy) begin
                    gcnt = 0;
                end else if ((o_s0_ready && i_s0_valid) || (o_s1_ready && i_s1_valid)) begin
                    gcnt++;
                    chk("burst_len_le_max", (gcnt <= BM), 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int t4_src[12]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int t4_last[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int t2_src[7]   = '{0, 0, 0, 1, 1, 0, 0};

    initial begin : main
        int acc;
        int t;
        i_s0_valid = 0; i_s0_last = 0; i_s0_r = 0; i_s0_g = 0; i_s0_b = 0;
        i_s1_valid = 0; i_s1_last = 0; i_s1_r = 0; i_s1_g = 0; i_s1_b = 0;
        i_ready = 1'b1;
        done0 = 1'b0; done1 = 1'b0;

        // Test 1: reset values, then one S0 burst of 4 identical beats.
        do_reset();
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_rgb", o_rgb565, 16'h0000);
        chk("rst_last", o_last, 0);
        chk("rst_src", o_src, 0);
        chk("rst_s0_ready", o_s0_ready, 0);
        chk("rst_s1_ready", o_s1_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_state", o_dbg_state, 0);
        mon_en = 1'b1;
        out_log.delete();
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) send(0, 8'hFF, 8'h80, 8'h07, (j == 3));
        wait_drain();
        chk("t1_count", out_log.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < out_log.size())
                chk("t1_beat", out_log[j], {1'b0, (j == 3), 16'hFC00});
        end
        chk("t1_idle", o_busy, 0);

        // Test 2: both valid after reset -> S0 first, then S1 despite S0 re-asserting.
        do_reset();
        mon_en = 1'b1;
        out_log.delete();
        fork
            begin
                for (int j = 0; j < 3; j++) send(0, 8'(8'h10 + j), 8'h20, 8'h30, (j == 2));
                for (int j = 0; j < 2; j++) send(0, 8'(8'h40 + j), 8'h50, 8'h60, (j == 1));
            end
            begin
                for (int j = 0; j < 2; j++) send(1, 8'hA0, 8'(8'hB0 + 4 * j), 8'hC8, (j == 1));
            end
        join
        wait_drain();
        chk("t2_count", out_log.size(), 7);
        for (int j = 0; j < 7; j++) begin
            if (j < out_log.size()) chk("t2_src_order", out_log[j][17], t2_src[j]);
        end

        // Test 3: downstream stall mid-burst.
        out_log.delete();
        fork
            for (int j = 0; j < 6; j++) send(0, 8'(8'h18 * j), 8'(8'hFF - 8'(j)), 8'h88, (j == 5));
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_s0_ready_stalled", o_s0_ready, 0);
                    chk("t3_valid_stalled", o_valid, 1);
                end
                @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t3_count", out_log.size(), 6);

        // Test 4: forced break at BURST_MAX with a competing S1 burst.
        out_log.delete();
        fork
            for (int j = 0; j < 10; j++) send(0, 8'(8'h08 * j), 8'h04, 8'(8'hF8 - 8'(8 * j)), 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int j = 0; j < 2; j++) send(1, 8'h55, 8'hAA, 8'(8'h10 + 8 * j), (j == 1));
            end
        join
        wait_drain();
        chk("t4_count", out_log.size(), 12);
        for (int j = 0; j < 12; j++) begin
            if (j < out_log.size()) begin
                chk("t4_src_order", out_log[j][17], t4_src[j]);
                chk("t4_last", out_log[j][16], t4_last[j]);
            end
        end

        // Test 5: reset in the middle of an S1 burst.
        do_reset();
        exp_q0.delete(); exp_q1.delete();
        i_s1_valid = 1'b1; i_s1_r = 8'h33; i_s1_g = 8'h66; i_s1_b = 8'h99; i_s1_last = 1'b0;
        acc = 0;
        t   = 0;
        while (acc < 2 && t < 100) begin
            @(negedge clk);
            if (o_s1_ready) acc++;
            t++;
            @(posedge clk);
            #1;
        end
        chk("t5_beats_before_rst", acc, 2);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk("t5_valid", o_valid, 0);
        chk("t5_s0_ready", o_s0_ready, 0);
        chk("t5_s1_ready", o_s1_ready, 0);
        chk("t5_state_idle", o_dbg_state, 0);
        i_s0_valid = 1'b1; i_s0_r = 8'hF0; i_s0_g = 8'h0C; i_s0_b = 8'h18; i_s0_last = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_grant_s0_state", o_dbg_state, 1);
        chk("t5_grant_s0_ready", o_s0_ready, 1);
        chk("t5_grant_s1_ready", o_s1_ready, 0);
        @(posedge clk);
        #1;
        i_s0_valid = 1'b0;
        i_s1_valid = 1'b0;
        chk("t5_out", {o_valid, o_src, o_last, o_rgb565}, {1'b1, 1'b0, 1'b1, 16'hF063});
        repeat (2) @(posedge clk);
        #1;
        chk("t5_drained", o_valid, 0);

        // Test 6: random traffic with backpressure, 5000 beats per source.
        exp_q0.delete(); exp_q1.delete();
        n_out0 = 0; n_out1 = 0;
        mon_en = 1'b1;
        fork
            begin src_stream(0, 5000); done0 = 1'b1; end
            begin src_stream(1, 5000); done1 = 1'b1; end
            begin
                while (!done0 || !done1) begin
                    @(posedge clk);
                    #1 i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t6_count_s0", n_out0, 5000);
        chk("t6_count_s1", n_out1, 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
